// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-requester round-robin arbiter onto one AHB-Lite master port
// Revision 1.0
// ============================================================================
module mem_arbiter #(
    parameter int         TIMEOUT = 16,
    parameter logic [2:0] HSIZE_W = 3'b010
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        m0_valid,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        HSEL,
    output logic [1:0]  HTRANS,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic             cap_write;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;
    logic [CNT_W-1:0] wait_cnt;

    logic             grant0;
    logic             grant1;
    logic             timeout_hit;
    logic             finish;
    logic             fin_err;
    logic [31:0]      fin_rdata;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        // last_grant=1 means port 1 was served last, so port 0 wins a tie
        if (HRESETn && (state == IDLE)) begin
            grant0 = m0_valid && (!m1_valid || last_grant);
            grant1 = m1_valid && !grant0;
        end
        // Abort on the edge that closes the TIMEOUT-th consecutive wait cycle
        timeout_hit = !HREADY && (wait_cnt == CNT_LAST);
        finish      = (state == DATA) && (HREADY || timeout_hit);
        fin_err     = !HREADY || (HRESP != 2'b00);
        fin_rdata   = (HREADY && !cap_write) ? HRDATA : 32'h0;
    end

    assign m0_ready = grant0;
    assign m1_ready = grant1;

    assign HSEL   = (state == ADDR);
    assign HTRANS = (state == ADDR) ? 2'b10 : 2'b00;
    assign HADDR  = cap_addr;
    assign HWRITE = cap_write;
    assign HSIZE  = HSIZE_W;
    assign HWDATA = (state != IDLE) ? cap_wdata : 32'h0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cap_write  <= 1'b0;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
            wait_cnt   <= '0;
            m0_done    <= 1'b0;
            m0_rdata   <= 32'h0;
            m0_err     <= 1'b0;
            m1_done    <= 1'b0;
            m1_rdata   <= 32'h0;
            m1_err     <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        cap_write  <= grant1 ? m1_write : m0_write;
                        cap_addr   <= grant1 ? m1_addr  : m0_addr;
                        cap_wdata  <= grant1 ? m1_wdata : m0_wdata;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (HREADY) begin
                        wait_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (finish) begin
                        state <= IDLE;
                        if (owner) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= fin_rdata;
                            m1_err   <= fin_err;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= fin_rdata;
                            m0_err   <= fin_err;
                        end
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter : directed stimulus against a wait-state memory slave, checked
// every cycle by a transaction-level reference model plus literal expectations.
module tb_mem_arbiter;

    localparam int TIMEOUT = 16;

    logic        HCLK     = 1'b0;
    logic        HRESETn  = 1'b1;
    logic        m0_valid = 1'b0;
    logic        m0_write = 1'b0;
    logic [31:0] m0_addr  = 32'h0;
    logic [31:0] m0_wdata = 32'h0;
    logic        m1_valid = 1'b0;
    logic        m1_write = 1'b0;
    logic [31:0] m1_addr  = 32'h0;
    logic [31:0] m1_wdata = 32'h0;
    logic        m0_ready, m0_done, m0_err, m1_ready, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        HSEL, HWRITE, HREADY;
    logic [1:0]  HTRANS, HRESP;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR, HWDATA, HRDATA;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 HCLK = ~HCLK;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .HSIZE_W(3'b010)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave: ws wait cycles in the data phase, resp_cfg returned on completion
    int          ws       = 0;
    logic [1:0]  resp_cfg = 2'b00;
    bit   [31:0] slave_mem [0:63];
    logic        s_dphase = 1'b0;
    int          s_cnt    = 0;
    logic [31:0] s_addr   = 32'h0;
    logic        s_write  = 1'b0;

    always_comb begin
        HREADY = !s_dphase || (s_cnt >= ws);
        HRDATA = (s_dphase && HREADY && !s_write) ? slave_mem[s_addr[7:2]] : 32'h0;
        HRESP  = (s_dphase && HREADY) ? resp_cfg : 2'b00;
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_dphase <= 1'b0;
            s_cnt    <= 0;
        end else begin
            if (s_dphase) begin
                if (HREADY) begin
                    s_dphase <= 1'b0;
                    if (s_write) slave_mem[s_addr[7:2]] <= HWDATA;
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end
            if (HSEL && (HTRANS == 2'b10) && HREADY) begin
                s_dphase <= 1'b1;
                s_cnt    <= 0;
                s_addr   <= HADDR;
                s_write  <= HWRITE;
            end
        end
    end

    // Reference model: one transfer record; completion edge computed from latency rules
    int          edge_n   = 0;
    bit          busy     = 1'b0;
    bit          last     = 1'b1;
    int          acc_e    = 0;
    int          end_e    = 0;
    bit          cur_p    = 1'b0;
    bit          cur_wr   = 1'b0;
    bit          cur_err  = 1'b0;
    bit          cur_to   = 1'b0;
    logic [31:0] cur_addr = 32'h0;
    logic [31:0] cur_wd   = 32'h0;
    bit   [31:0] ref_mem [0:63];
    logic        e_done0 = 1'b0, e_done1 = 1'b0, e_err0 = 1'b0, e_err1 = 1'b0;
    logic [31:0] e_rd0 = 32'h0, e_rd1 = 32'h0;
    logic        win0, win1;

    assign win0 = m0_valid && (!m1_valid || last);
    assign win1 = m1_valid && !win0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            busy    <= 1'b0;
            last    <= 1'b1;
            e_done0 <= 1'b0;
            e_done1 <= 1'b0;
            e_err0  <= 1'b0;
            e_err1  <= 1'b0;
            e_rd0   <= 32'h0;
            e_rd1   <= 32'h0;
        end else begin
            edge_n  <= edge_n + 1;
            e_done0 <= 1'b0;
            e_done1 <= 1'b0;
            if (!busy) begin
                if (win0 || win1) begin
                    busy     <= 1'b1;
                    cur_p    <= win1;
                    last     <= win1;
                    cur_wr   <= win1 ? m1_write : m0_write;
                    cur_addr <= win1 ? m1_addr  : m0_addr;
                    cur_wd   <= win1 ? m1_wdata : m0_wdata;
                    acc_e    <= edge_n + 1;
                    end_e    <= edge_n + 1 + ((ws >= TIMEOUT) ? (1 + TIMEOUT) : (2 + ws));
                    cur_to   <= (ws >= TIMEOUT);
                    cur_err  <= (ws >= TIMEOUT) || (resp_cfg != 2'b00);
                end
            end else if (edge_n + 1 == end_e) begin
                busy <= 1'b0;
                if (cur_p) begin
                    e_done1 <= 1'b1;
                    e_err1  <= cur_err;
                    e_rd1   <= (cur_to || cur_wr) ? 32'h0 : ref_mem[cur_addr[7:2]];
                end else begin
                    e_done0 <= 1'b1;
                    e_err0  <= cur_err;
                    e_rd0   <= (cur_to || cur_wr) ? 32'h0 : ref_mem[cur_addr[7:2]];
                end
                if (cur_wr && !cur_to) ref_mem[cur_addr[7:2]] <= cur_wd;
            end
        end
    end

    always @(negedge HCLK) begin
        chk("m0_ready", m0_ready, HRESETn && !busy && win0);
        chk("m1_ready", m1_ready, HRESETn && !busy && win1);
        chk("m0_done", m0_done, e_done0);
        chk("m1_done", m1_done, e_done1);
        chk("m0_rdata", m0_rdata, e_rd0);
        chk("m1_rdata", m1_rdata, e_rd1);
        chk("m0_err", m0_err, e_err0);
        chk("m1_err", m1_err, e_err1);
        chk("HSEL", HSEL, busy && (edge_n == acc_e));
        chk("HTRANS", HTRANS, (busy && (edge_n == acc_e)) ? 32'h2 : 32'h0);
        chk("HWDATA", HWDATA, busy ? cur_wd : 32'h0);
        chk("HSIZE", HSIZE, 32'h2);
        if (busy) begin
            chk("HADDR", HADDR, cur_addr);
            chk("HWRITE", HWRITE, cur_wr);
        end
    end

    int nonseq_n = 0;
    always @(negedge HCLK) if (HTRANS == 2'b10) nonseq_n <= nonseq_n + 1;

    task automatic sync();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_req(input bit p, input bit v, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            m1_valid = v; m1_write = wr; m1_addr = a; m1_wdata = d;
        end else begin
            m0_valid = v; m0_write = wr; m0_addr = a; m0_wdata = d;
        end
    endtask

    // Returns the edge number at which the request was accepted
    task automatic request(input bit p, input bit wr, input logic [31:0] a, input logic [31:0] d, output int acc);
        bit got = 1'b0;
        acc = -1000;
        set_req(p, 1'b1, wr, a, d);
        for (int i = 0; i < 100; i++) begin
            @(negedge HCLK);
            if (p ? m1_ready : m0_ready) begin
                sync();
                acc = edge_n;
                got = 1'b1;
                break;
            end
        end
        set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("accept_seen", got, 1);
    endtask

    // Returns the edge number after which the done pulse of port p is visible
    task automatic wait_done(input bit p, output int de);
        bit found = 1'b0;
        de = 1000000;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (p ? m1_done : m0_done) begin
                de = edge_n;
                found = 1'b1;
                break;
            end
        end
        chk("done_seen", found, 1);
    endtask

    initial begin
        int acc, de, n0, gn;
        int g [4];
        for (int i = 0; i < 4; i++) g[i] = 9;

        #1 HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_HSEL", HSEL, 0);
        chk("rst_HTRANS", HTRANS, 0);
        chk("rst_HSIZE", HSIZE, 32'h2);
        chk("rst_HWDATA", HWDATA, 0);
        chk("rst_HADDR", HADDR, 0);
        chk("rst_m0_done", m0_done, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        HRESETn = 1'b1;

        // m0 write, two data-phase wait states
        ws = 2;
        n0 = nonseq_n;
        request(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, acc);
        wait_done(1'b0, de);
        chk("wr_latency", de - acc, 4);
        chk("wr_err", m0_err, 0);
        chk("wr_nonseq_cycles", nonseq_n - n0, 1);
        sync();

        // m1 reads it back with zero wait states
        ws = 0;
        request(1'b1, 1'b0, 32'h10, 32'h0, acc);
        wait_done(1'b1, de);
        chk("rd_latency", de - acc, 2);
        chk("rd_m1_rdata", m1_rdata, 32'hDEADBEEF);
        chk("rd_m1_err", m1_err, 0);
        chk("rd_m0_rdata_kept", m0_rdata, 0);
        chk("rd_m0_err_kept", m0_err, 0);
        sync();

        // Contention straight after reset, both requests held
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h11111111);
        set_req(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        gn = 0;
        for (int i = 0; i < 60 && gn < 4; i++) begin
            @(negedge HCLK);
            chk("both_ready", m0_ready & m1_ready, 0);
            if (m0_ready) begin
                g[gn] = 0; gn++;
            end else if (m1_ready) begin
                g[gn] = 1; gn++;
            end
        end
        sync();
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("grant_count", gn, 4);
        chk("grant0", g[0], 0);
        chk("grant1", g[1], 1);
        chk("grant2", g[2], 0);
        chk("grant3", g[3], 1);
        repeat (6) sync();
        chk("rr_m1_rdata", m1_rdata, 32'h11111111);

        // Error response
        ws = 1;
        resp_cfg = 2'b01;
        request(1'b1, 1'b0, 32'h10, 32'h0, acc);
        wait_done(1'b1, de);
        chk("resp_latency", de - acc, 3);
        chk("resp_m1_err", m1_err, 1);
        chk("resp_m1_rdata", m1_rdata, 32'hDEADBEEF);
        sync();
        resp_cfg = 2'b00;

        // m0 read so rdata is non-zero before the timeout clears it
        ws = 0;
        request(1'b0, 1'b0, 32'h10, 32'h0, acc);
        wait_done(1'b0, de);
        chk("pre_to_m0_rdata", m0_rdata, 32'hDEADBEEF);
        sync();

        // Slave stalls past TIMEOUT
        ws = 40;
        request(1'b0, 1'b0, 32'h10, 32'h0, acc);
        wait_done(1'b0, de);
        chk("to_latency", de - acc, 17);
        chk("to_m0_err", m0_err, 1);
        chk("to_m0_rdata", m0_rdata, 0);
        chk("to_m1_err_kept", m1_err, 1);
        chk("to_m1_rdata_kept", m1_rdata, 32'hDEADBEEF);
        repeat (45) sync();

        // Reset asserted in the data phase
        ws = 5;
        request(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, acc);
        repeat (2) sync();
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_HWDATA", HWDATA, 0);
        chk("arst_HADDR", HADDR, 0);
        chk("arst_HWRITE", HWRITE, 0);
        chk("arst_m0_err", m0_err, 0);
        chk("arst_m1_rdata", m1_rdata, 0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        ws = 0;
        request(1'b0, 1'b1, 32'h30, 32'h12345678, acc);
        wait_done(1'b0, de);
        chk("post_rst_latency", de - acc, 2);
        chk("post_rst_err", m0_err, 0);
        sync();
        request(1'b1, 1'b0, 32'h30, 32'h0, acc);
        wait_done(1'b1, de);
        chk("post_rst_rdata", m1_rdata, 32'h12345678);
        sync();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
